// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the seven-segment scan driver:
//   - active-low segment patterns (bit7 = dp, bit6..0 = g..a), common anode
//   - scan FSM state type
// ---------------------------------------------------------------------------
package seg_pkg;

  localparam logic [7:0] SEG_0    = 8'hC0;
  localparam logic [7:0] SEG_1    = 8'hF9;
  localparam logic [7:0] SEG_2    = 8'hA4;
  localparam logic [7:0] SEG_3    = 8'hB0;
  localparam logic [7:0] SEG_4    = 8'h99;
  localparam logic [7:0] SEG_5    = 8'h92;
  localparam logic [7:0] SEG_6    = 8'h82;
  localparam logic [7:0] SEG_7    = 8'hF8;
  localparam logic [7:0] SEG_8    = 8'h80;
  localparam logic [7:0] SEG_9    = 8'h90;
  localparam logic [7:0] SEG_DASH = 8'hBF;
  localparam logic [7:0] SEG_OFF  = 8'hFF;

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/bcd_to_seg.sv
// ---------------------------------------------------------------------------
// bcd_to_seg
// Purely combinational BCD to seven-segment decoder (common anode, dp off).
// Non-BCD codes 10..15 render as a dash.
//   bcd : 4-bit digit value
//   seg : active-low segment pattern
// ---------------------------------------------------------------------------
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] seg
);

  // Digit lookup.
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan_drv.sv
// ---------------------------------------------------------------------------
// seg_scan_drv
// Time-multiplexed seven-segment scan driver. Each digit is lit for SCAN_DIV
// clocks, separated by BLANK_CYC all-off clocks. bcd_in is copied into a
// shadow register only at the frame boundary (BLANK->SHOW with idx 0), so a
// frame is never torn.
//   clk, rst_n  : clock, asynchronous active-low reset
//   bcd_in      : packed BCD digits, digit i = bcd_in[4i+3:4i]
//   load        : capture request, serviced at the next frame boundary
//   seg         : active-low segments (registered)
//   sel         : active-low one-hot digit enable (registered)
//   frame_done  : one-clock pulse after the last digit of a frame
// Build option: define SEG_SCAN_LZB_EN for leading-zero blanking.
// ---------------------------------------------------------------------------
module seg_scan_drv
  import seg_pkg::*;
#(
  parameter int DIGITS    = 6,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  load,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     sel,
  output logic                  frame_done
);

  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

  scan_state_t           state_r, state_nxt_s;
  logic [IDX_W-1:0]      idx_r, idx_nxt_s;
  logic [CNT_W-1:0]      cnt_r, cnt_nxt_s;
  logic                  pend_r, pend_nxt_s;
  logic [4*DIGITS-1:0]   shadow_r, shadow_nxt_s;
  logic                  frame_done_nxt_s;
  logic [3:0]            digit_s;
  logic [7:0]            dec_s;
  logic                  blank_lz_s;
  logic [7:0]            seg_nxt_s;
  logic [DIGITS-1:0]     sel_nxt_s;
  logic [7:0]            seg_r;
  logic [DIGITS-1:0]     sel_r;
  logic                  frame_done_r;

  // Scan sequencing, load pending flag and shadow capture.
  always_comb begin
    state_nxt_s      = state_r;
    idx_nxt_s        = idx_r;
    cnt_nxt_s        = cnt_r + CNT_W'(1);
    pend_nxt_s       = pend_r | load;
    shadow_nxt_s     = shadow_r;
    frame_done_nxt_s = 1'b0;
    case (state_r)
      BLANK: begin
        if (cnt_r == BLANK_LAST) begin
          state_nxt_s = SHOW;
          cnt_nxt_s   = '0;
          // Frame boundary: a load in this very cycle counts as well.
          if ((idx_r == '0) && (pend_r || load)) begin
            shadow_nxt_s = bcd_in;
            pend_nxt_s   = 1'b0;
          end else begin
            shadow_nxt_s = shadow_r;
          end
        end else begin
          state_nxt_s = BLANK;
        end
      end
      SHOW: begin
        if (cnt_r == SHOW_LAST) begin
          state_nxt_s = BLANK;
          cnt_nxt_s   = '0;
          if (idx_r == IDX_LAST) begin
            idx_nxt_s        = '0;
            frame_done_nxt_s = 1'b1;
          end else begin
            idx_nxt_s = idx_r + IDX_W'(1);
          end
        end else begin
          state_nxt_s = SHOW;
        end
      end
      default: begin
        state_nxt_s = BLANK;
        idx_nxt_s   = '0;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // Select the digit about to be shown; outputs follow the next state so the
  // display changes on the same edge as the FSM.
  always_comb begin
    digit_s = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_nxt_s == IDX_W'(i)) begin
        digit_s = shadow_nxt_s[4*i +: 4];
      end else begin
        digit_s = digit_s;
      end
    end
  end

  bcd_to_seg u_dec (
    .bcd (digit_s),
    .seg (dec_s)
  );

`ifdef SEG_SCAN_LZB_EN
  // Leading-zero detection: a digit blanks when it and every higher digit are
  // zero; digit 0 is never considered.
  always_comb begin
    logic seen_nz;
    seen_nz    = 1'b0;
    blank_lz_s = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (shadow_nxt_s[4*i +: 4] != 4'd0) begin
        seen_nz = 1'b1;
      end else begin
        seen_nz = seen_nz;
      end
      if (!seen_nz && (idx_nxt_s == IDX_W'(i))) begin
        blank_lz_s = 1'b1;
      end else begin
        blank_lz_s = blank_lz_s;
      end
    end
  end
`else
  assign blank_lz_s = 1'b0;
`endif

  // Next output values for the registered seg/sel.
  always_comb begin
    sel_nxt_s = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if ((state_nxt_s == SHOW) && (idx_nxt_s == IDX_W'(i))) begin
        sel_nxt_s[i] = 1'b0;
      end else begin
        sel_nxt_s[i] = 1'b1;
      end
    end
    if (state_nxt_s == SHOW) begin
      seg_nxt_s = blank_lz_s ? SEG_OFF : dec_s;
    end else begin
      seg_nxt_s = SEG_OFF;
    end
  end

  // State, shadow and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= BLANK;
      idx_r        <= '0;
      cnt_r        <= '0;
      pend_r       <= 1'b0;
      shadow_r     <= '0;
      seg_r        <= SEG_OFF;
      sel_r        <= '1;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      idx_r        <= idx_nxt_s;
      cnt_r        <= cnt_nxt_s;
      pend_r       <= pend_nxt_s;
      shadow_r     <= shadow_nxt_s;
      seg_r        <= seg_nxt_s;
      sel_r        <= sel_nxt_s;
      frame_done_r <= frame_done_nxt_s;
    end
  end

  assign seg        = seg_r;
  assign sel        = sel_r;
  assign frame_done = frame_done_r;

endmodule

// File: doc/seg_scan_drv.md
# seg_scan_drv

Time-multiplexed seven-segment display driver for the multi-digit BCD counter chain. Consumes the packed BCD digits produced by the cascaded decimal counter stages and scans them onto a common-anode display. Each digit is shown for a fixed period, followed by an all-off blanking gap that suppresses ghosting. Digit values are captured into a shadow register only at frame boundaries, so no frame is ever torn.

## Interface
- `DIGITS`, 6: number of display digits; index 0 is least significant.
- `SCAN_DIV`, 50000: clocks each digit is lit (1 kHz/digit at 50 MHz); must be ≥2.
- `BLANK_CYC`, 16: clocks of all-off gap between digits; must be ≥1.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `bcd_in` in 4*DIGITS: packed BCD; digit i = `bcd_in[4i+3:4i]`.
- `load` in 1: request to capture `bcd_in` into the shadow register at the next frame boundary.
- `seg` out 8: active-low segments; bit7=dp, bit6..0 = g..a.
- `sel` out DIGITS: active-low one-hot digit enable.
- `frame_done` out 1: one-clock pulse after the last digit of each frame.

## Operation
- FSM states `BLANK`, `SHOW`; the state machine also maintains a digit index `idx` (0..DIGITS-1) and a cycle counter `cnt`.
- `BLANK`: `sel` all ones and `seg`=8'hFF. `cnt` counts 0..BLANK_CYC-1. At the terminal count the FSM moves to `SHOW`; `cnt` clears.
- `SHOW`: `sel[idx]`=0, all other `sel` bits are 1, and `seg` is the decoded shadow digit `idx`. `cnt` counts 0..SCAN_DIV-1. At the terminal count the FSM moves to `BLANK`, and `idx` advances, wrapping from DIGITS-1 to 0.
- Frame boundary: the `BLANK`→`SHOW` transition with `idx`=0.
- Load handling:
  - A `load` pulse sets `pend`.
  - At a frame boundary with `pend`=1 or `load`=1, the shadow register copies `bcd_in` sampled that cycle, and `pend` clears.
  - Repeated `load` pulses within one frame collapse into one capture.
- `frame_done` pulses on the `SHOW`→`BLANK` transition taken with `idx`=DIGITS-1.
- Decode (common anode, dp off): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90. Non-BCD values 10–15 display a dash, 8'hBF.
- Reset values: state `BLANK`, `idx`=0, `cnt`=0, `pend`=0, shadow all zero, `seg`=8'hFF, `sel` all ones, `frame_done`=0.
- Reset asserted mid-scan forces all outputs to their reset values immediately, asynchronously.

## Timing
- All outputs are registered. `seg`/`sel` reflect a state change on the clock edge that performs it; there is no extra pipeline stage.
- Digit period is SCAN_DIV+BLANK_CYC clocks. Frame period is DIGITS*(SCAN_DIV+BLANK_CYC).
- After reset release, digit 0 first lights after BLANK_CYC clock edges.
- A capture becomes visible on the same edge as the frame-boundary transition. `bcd_in` latency is at most one frame plus BLANK_CYC.
- `bcd_in` need only be stable in the cycle of the frame boundary. No handshake back to the counters; `load` is fire-and-forget.

## Configuration
- `SEG_SCAN_LZB_EN` defined: leading-zero blanking. Working from index DIGITS-1 downward, every shadow digit equal to 0 is displayed as 8'hFF until the first non-zero digit. Digit 0 is always displayed. `sel` timing is unchanged.
- Not defined: every digit is displayed as decoded, including leading zeros.

## Structure
- Package `seg_pkg`:
  - segment pattern constants `SEG_0`..`SEG_9`, `SEG_DASH`, `SEG_OFF`;
  - FSM state typedef `scan_state_t`.
- Sub-module `bcd_to_seg`: purely combinational 4-bit → 8-bit decoder, instantiated once on the selected shadow digit. The output register lives in `seg_scan_drv`.

## Test plan
All scenarios use DIGITS=4, SCAN_DIV=4, BLANK_CYC=2.
- Reset, then `load`=1 for one cycle with `bcd_in`=16'h1234. Expected sequence:
  - `seg`=FF and `sel`=F for 2 clocks;
  - `sel`=E with `seg`=99 for 4 clocks;
  - 2 blank clocks;
  - `sel`=D with `seg`=B0, then 2 blank clocks;
  - `sel`=B with `seg`=A4, then 2 blank clocks;
  - `sel`=7 with `seg`=F9;
  - `frame_done` pulses once, on the 24th clock after reset release.
- Change `bcd_in` from 16'h1234 to 16'h5678 mid-frame with `load` pulsed: digits keep showing 1234 until the next boundary, then 8 (80) appears on `sel`=E.
- `bcd_in`=16'hA0F9 loaded: digit 0 shows 90, digit 1 shows BF, digit 2 shows C0, digit 3 shows BF.
- With `SEG_SCAN_LZB_EN`, `bcd_in`=16'h0005: digits 3..1 show FF with `sel` still cycling, and digit 0 shows 92. With 16'h0000, only digit 0 shows C0.
- Assert `rst_n`=0 while `sel`=B: `seg`=FF, `sel`=F, `frame_done`=0 in the same cycle. After release, the scan restarts at the BLANK gap, then digit 0 with shadow value 0 (C0).
- `load` held high continuously: exactly one capture per frame, always at the boundary. `frame_done` is never wider than one clock.
